menu_controller: RTL and testbench

//  Owns the user-settable state shown by the VGA display: menu page, temperature and

---
 rtl/menu_controller.sv | 150 +++++++++++++++
 tb/tb_menu_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/menu_controller.sv
// Menu/setpoint/clock controller: turns debounced UP/DOWN/MENU buttons into page
// changes and field edits, keeps wall-clock time, and falls back to IDLE when left alone.
//
// state      | meaning
// S_IDLE     | idle page, UP/DOWN ignored
// S_TEMP     | editing temperature setpoint
// S_HUM      | editing humidity setpoint
// S_HOURS    | editing clock hours
// S_MINUTES  | editing clock minutes
module menu_controller #(
  parameter int unsigned TICKS_PER_MIN  = 32'd3_000_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 32'd500_000_000,
  parameter int unsigned TEMP_MIN       = 32'd40,
  parameter int unsigned TEMP_MAX       = 32'd99,
  parameter int unsigned TEMP_DEFAULT   = 32'd72,
  parameter int unsigned HUM_DEFAULT    = 32'd50
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        BTN_MENU,
  input  logic        BTN_UP,
  input  logic        BTN_DOWN,
  output logic [3:0]  MENU_STATE,
  output logic [11:0] SET_TEMP_F,
  output logic [7:0]  SET_HUM,
  output logic [4:0]  TIME_HOURS,
  output logic [5:0]  TIME_MINUTES
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_TEMP    = 4'd1,
    S_HUM     = 4'd2,
    S_HOURS   = 4'd3,
    S_MINUTES = 4'd4
  } state_t;

  localparam logic [11:0] T_MIN = TEMP_MIN[11:0];
  localparam logic [11:0] T_MAX = TEMP_MAX[11:0];
  localparam logic [11:0] T_DEF = TEMP_DEFAULT[11:0];
  localparam logic [7:0]  H_DEF = HUM_DEFAULT[7:0];

  state_t      state_q, state_d;
  logic [11:0] temp_q, temp_d;
  logic [7:0]  hum_q, hum_d;
  logic [4:0]  hours_q, hours_d;
  logic [5:0]  mins_q, mins_d;
  logic [31:0] presc_q, presc_d;
  logic [31:0] tmo_q, tmo_d;

  // bit order {menu, up, down}; held masks a button that was high through reset
  logic [2:0] btn_raw, btn_q1, btn_q2, btn_held;
  logic [2:0] press;
  logic       press_menu, step_up, step_dn, any_press, tick, time_edit;

  assign btn_raw    = {BTN_MENU, BTN_UP, BTN_DOWN};
  assign press      = btn_q1 & ~btn_q2 & ~btn_held;
  assign press_menu = press[2];
  assign step_up    = press[1] & ~press[0] & ~press_menu;
  assign step_dn    = press[0] & ~press[1] & ~press_menu;
  assign any_press  = |press;
  assign tick       = (presc_q == TICKS_PER_MIN - 32'd1);
  assign time_edit  = ((state_q == S_HOURS) || (state_q == S_MINUTES)) && (step_up || step_dn);

  always_comb begin
    state_d = state_q;
    temp_d  = temp_q;
    hum_d   = hum_q;
    hours_d = hours_q;
    mins_d  = mins_q;
    presc_d = tick ? 32'd0 : presc_q + 32'd1;
    tmo_d   = tmo_q + 32'd1;

    // a user time edit swallows a coincident minute tick
    if (tick && !time_edit) begin
      if (mins_q == 6'd59) begin
        mins_d  = 6'd0;
        hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
      end else begin
        mins_d = mins_q + 6'd1;
      end
    end
    if (time_edit) presc_d = 32'd0;

    case (state_q)
      S_IDLE: if (press_menu) state_d = S_TEMP;
      S_TEMP: begin
        if (press_menu) state_d = S_HUM;
        else if (step_up && temp_q < T_MAX) temp_d = temp_q + 12'd1;
        else if (step_dn && temp_q > T_MIN) temp_d = temp_q - 12'd1;
      end
      S_HUM: begin
        if (press_menu) state_d = S_HOURS;
        else if (step_up && hum_q < 8'd99) hum_d = hum_q + 8'd1;
        else if (step_dn && hum_q > 8'd0) hum_d = hum_q - 8'd1;
      end
      S_HOURS: begin
        if (press_menu) state_d = S_MINUTES;
        else if (step_up) hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
        else if (step_dn) hours_d = (hours_q == 5'd0) ? 5'd23 : hours_q - 5'd1;
      end
      S_MINUTES: begin
        if (press_menu) state_d = S_IDLE;
        else if (step_up) mins_d = (mins_q == 6'd59) ? 6'd0 : mins_q + 6'd1;
        else if (step_dn) mins_d = (mins_q == 6'd0) ? 6'd59 : mins_q - 6'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_IDLE || any_press) begin
      tmo_d = 32'd0;
    end else if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
      tmo_d   = 32'd0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      temp_q   <= T_DEF;
      hum_q    <= H_DEF;
      hours_q  <= 5'd0;
      mins_q   <= 6'd0;
      presc_q  <= 32'd0;
      tmo_q    <= 32'd0;
      btn_q1   <= 3'b000;
      btn_q2   <= 3'b000;
      btn_held <= 3'b111;
    end else begin
      state_q  <= state_d;
      temp_q   <= temp_d;
      hum_q    <= hum_d;
      hours_q  <= hours_d;
      mins_q   <= mins_d;
      presc_q  <= presc_d;
      tmo_q    <= tmo_d;
      btn_q1   <= btn_raw;
      btn_q2   <= btn_q1;
      btn_held <= btn_held & btn_raw;
    end
  end

  assign MENU_STATE   = state_q;
  assign SET_TEMP_F   = temp_q;
  assign SET_HUM      = hum_q;
  assign TIME_HOURS   = hours_q;
  assign TIME_MINUTES = mins_q;

endmodule

// File: tb/tb_menu_controller.sv
// Directed bench for menu_controller with a 10-cycle minute and 50-cycle timeout:
// a vector table for page/setpoint edits plus timed sequences for clock and timeout cases.
module tb_menu_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_menu = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic [3:0]  menu_state;
  logic [11:0] set_temp_f;
  logic [7:0]  set_hum;
  logic [4:0]  time_hours;
  logic [5:0]  time_minutes;

  int tests = 0;
  int fails = 0;

  menu_controller #(
    .TICKS_PER_MIN(10),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .CLOCK_50(clk),
    .RESET(rst),
    .BTN_MENU(btn_menu),
    .BTN_UP(btn_up),
    .BTN_DOWN(btn_down),
    .MENU_STATE(menu_state),
    .SET_TEMP_F(set_temp_f),
    .SET_HUM(set_hum),
    .TIME_HOURS(time_hours),
    .TIME_MINUTES(time_minutes)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       menu;
    logic       up;
    logic       down;
    logic [3:0] exp_state;
    int         exp_temp;
    int         exp_hum;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic m, input logic u, input logic d);
    btn_menu = m; btn_up = u; btn_down = d;
    step(1);
    btn_menu = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    step(1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " state"}, 32'(menu_state), 32'd0);
    check({tag, " temp"}, 32'(set_temp_f), 32'd72);
    check({tag, " hum"}, 32'(set_hum), 32'd50);
    check({tag, " hours"}, 32'(time_hours), 32'd0);
    check({tag, " minutes"}, 32'(time_minutes), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_menu = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    step(2);
    check_reset_vals("reset");
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 4'd0, 72, 50};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'd1, 72, 50};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'd1, 73, 50};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 4'd1, 72, 50};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'd1, 71, 50};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 4'd1, 71, 50};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 4'd2, 71, 50};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'd2, 71, 51};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'd2, 71, 50};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'd2, 71, 49};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 4'd3, 71, 49};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 4'd4, 71, 49};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 4'd0, 71, 49};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 4'd0, 71, 49};

    // table: page stepping and setpoint edits
    do_reset();
    for (int i = 0; i < 14; i++) begin
      pulse(vecs[i].menu, vecs[i].up, vecs[i].down);
      check($sformatf("vec%0d state", i), 32'(menu_state), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d temp", i), 32'(set_temp_f), 32'(vecs[i].exp_temp));
      check($sformatf("vec%0d hum", i), 32'(set_hum), 32'(vecs[i].exp_hum));
    end

    // held MENU gives exactly one press, two edges after the first sample
    do_reset();
    btn_menu = 1'b1;
    step(1);
    check("hold sampled", 32'(menu_state), 32'd0);
    step(1);
    check("hold acts", 32'(menu_state), 32'd1);
    step(18);
    check("hold single press", 32'(menu_state), 32'd1);
    btn_menu = 1'b0;
    step(1);

    // temperature saturation
    for (int i = 0; i < 30; i++) pulse(1'b0, 1'b1, 1'b0);
    check("temp sat max", 32'(set_temp_f), 32'd99);
    for (int i = 0; i < 70; i++) pulse(1'b0, 1'b0, 1'b1);
    check("temp sat min", 32'(set_temp_f), 32'd40);

    // hour/minute wrap; edge numbering counts from reset release
    do_reset();                                   // edge 1
    pulse(1'b1, 1'b0, 1'b0);                      // 2,3  TEMP
    pulse(1'b1, 1'b0, 1'b0);                      // 4,5  HUM
    pulse(1'b1, 1'b0, 1'b0);                      // 6,7  HOURS
    pulse(1'b0, 1'b0, 1'b1);                      // 8,9
    check("hours 0 down", 32'(time_hours), 32'd23);
    check("minutes before wrap", 32'(time_minutes), 32'd0);
    pulse(1'b0, 1'b1, 1'b0);                      // 10,11
    check("hours 23 up", 32'(time_hours), 32'd0);
    pulse(1'b1, 1'b0, 1'b0);                      // 12,13 MINUTES
    pulse(1'b0, 1'b0, 1'b1);                      // 14,15
    check("minutes 0 down", 32'(time_minutes), 32'd59);
    check("minutes no borrow", 32'(time_hours), 32'd0);

    // build 23:59; the hours edit at edge 25 lands on a tick, which must be dropped
    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0, 1'b0); // 16..23 HOURS
    pulse(1'b0, 1'b0, 1'b1);                      // 24,25
    check("edit beats tick hours", 32'(time_hours), 32'd23);
    check("edit beats tick minutes", 32'(time_minutes), 32'd59);
    step(9);                                      // 34
    check("before rollover", 32'(time_minutes), 32'd59);
    step(1);                                      // 35
    check("rollover hours", 32'(time_hours), 32'd0);
    check("rollover minutes", 32'(time_minutes), 32'd0);

    // minute edit coincident with tick at edge 45
    pulse(1'b1, 1'b0, 1'b0);                      // 36,37 MINUTES
    check("state minutes", 32'(menu_state), 32'd4);
    step(6);                                      // 43
    pulse(1'b0, 1'b1, 1'b0);                      // 44,45
    check("up with tick", 32'(time_minutes), 32'd1);
    check("up with tick hours", 32'(time_hours), 32'd0);
    step(4);                                      // 49
    pulse(1'b0, 1'b1, 1'b0);                      // 50,51 prescaler cleared here
    check("mid edit", 32'(time_minutes), 32'd2);
    step(5);                                      // 56
    check("prescaler restarted", 32'(time_minutes), 32'd2);
    step(5);                                      // 61
    check("tick after restart", 32'(time_minutes), 32'd3);

    // inactivity timeout on SET_HUM
    pulse(1'b1, 1'b0, 1'b0);
    check("back to idle", 32'(menu_state), 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    step(49);
    check("timeout not yet", 32'(menu_state), 32'd2);
    step(1);
    check("timeout fires", 32'(menu_state), 32'd0);

    // press on the final idle cycle wins and restarts the count
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    step(48);
    pulse(1'b0, 1'b1, 1'b0);
    check("late press state", 32'(menu_state), 32'd2);
    check("late press hum", 32'(set_hum), 32'd51);
    step(49);
    check("count restarted", 32'(menu_state), 32'd2);
    step(1);
    check("second timeout", 32'(menu_state), 32'd0);

    // UP+DOWN no-op, then reset mid-edit with MENU held through it
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    check("hum to 50", 32'(set_hum), 32'd50);
    pulse(1'b0, 1'b1, 1'b1);
    check("up+down hum", 32'(set_hum), 32'd50);
    check("up+down state", 32'(menu_state), 32'd2);
    pulse(1'b0, 1'b0, 1'b1);
    check("hum to 49", 32'(set_hum), 32'd49);
    btn_menu = 1'b1;
    rst = 1'b1;
    step(1);
    check_reset_vals("mid reset");
    rst = 1'b0;
    step(6);
    check("held after reset", 32'(menu_state), 32'd0);
    btn_menu = 1'b0;
    step(1);
    btn_menu = 1'b1;
    step(1);
    check("repress sampled", 32'(menu_state), 32'd0);
    btn_menu = 1'b0;
    step(1);
    check("repress acts", 32'(menu_state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
